// File: rtl/seg_scan_if.sv
// ============================================================================
// seg_scan_if : nibble-string input and multiplexed 7-segment display outputs
// Rev 1.0
// ============================================================================
`default_nettype none

interface seg_scan_if #(
  parameter int W     = 52,
  parameter int N_DIG = 8
);
  logic [W-1:0]     data;
  logic             frz;
  logic [N_DIG-1:0] an;
  logic [6:0]       seg;
  logic             shift_en;

  // master: the string source and control side; slave: the display scanner
  modport master (output data, output frz, input an, input seg, input shift_en);
  modport slave  (input data, input frz, output an, output seg, output shift_en);
endinterface

`default_nettype wire

// File: rtl/seg_scan.sv
// ============================================================================
// seg_scan : time-multiplexed common-anode 7-segment scanner with shift pacing
// Rev 1.0
// ============================================================================
`default_nettype none

module seg_scan #(
  parameter int         W            = 52,
  parameter int         N_DIG        = 8,
  parameter int         SCAN_DIV     = 50000,
  parameter int         GHOST        = 8,
  parameter int         SHIFT_FRAMES = 100,
  parameter logic [3:0] BLANK_CODE   = 4'hA,
  parameter bit         BLANK_EN     = 1'b1
) (
  input  wire logic  clk,
  input  wire logic  rst,
  seg_scan_if.slave  bus
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int NW = $clog2(N_DIG);
  localparam int FW = (SHIFT_FRAMES > 1) ? $clog2(SHIFT_FRAMES) : 1;
  localparam int DW = 4 * N_DIG;

  localparam logic [CW-1:0] CNT_LAST   = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] GHOST_LAST = CW'((GHOST > 0) ? GHOST - 1 : 0);
  localparam logic [NW-1:0] DIG_LAST   = NW'(N_DIG - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(SHIFT_FRAMES - 1);

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [NW-1:0]    nxt_q, nxt_d;
  logic [NW-1:0]    shown_q, shown_d;
  logic             lit_q, lit_d;
  logic [FW-1:0]    frame_q, frame_d;
  logic [DW-1:0]    snap_q, snap_d;
  logic [6:0]       seg_q, seg_d;
  logic [N_DIG-1:0] an_q, an_d;
  logic             shift_q, shift_d;

  logic                 w_tick;
  logic                 w_frame_end;
  logic [DW-1:0]        w_top;
  logic [DW-1:0]        w_src;
  logic [N_DIG-1:0][3:0] w_digs;
  logic [3:0]           w_nib;
  logic                 w_data_unused;

  assign w_top         = bus.data[W-1 -: DW];
  assign w_data_unused = ^bus.data;
  assign w_tick        = (cnt_q == CNT_LAST);
  assign w_frame_end   = w_tick && (nxt_q == DIG_LAST);
  // Digit 0 reads the live string; later digits read the frame snapshot
  assign w_src         = (nxt_q == '0) ? w_top : snap_q;

  for (genvar i = 0; i < N_DIG; i++) begin : g_dig
    assign w_digs[i] = w_src[DW-1-4*i -: 4];
  end

  assign w_nib = w_digs[nxt_q];

  always_comb begin
    cnt_d   = w_tick ? '0 : cnt_q + CW'(1);
    nxt_d   = nxt_q;
    shown_d = shown_q;
    lit_d   = lit_q;
    frame_d = frame_q;
    snap_d  = snap_q;
    seg_d   = seg_q;
    an_d    = an_q;
    shift_d = 1'b0;

    if (w_tick) begin
      if (nxt_q == '0) snap_d = w_top;
      seg_d = (BLANK_EN && (w_nib == BLANK_CODE)) ? 7'h7F : hex7(w_nib);
      nxt_d   = (nxt_q == DIG_LAST) ? '0 : nxt_q + NW'(1);
      shown_d = nxt_q;
      lit_d   = 1'b1;
      if (GHOST == 0) an_d = ~(N_DIG'(1) << nxt_q);
      else            an_d = '1;
    end else if (lit_q && (GHOST != 0) && (cnt_q == GHOST_LAST)) begin
      an_d = ~(N_DIG'(1) << shown_q);
    end

    // Freeze pins the frame count at zero so release always starts a full period
    if (bus.frz) begin
      frame_d = '0;
    end else if (w_frame_end) begin
      if (frame_q == FRAME_LAST) begin
        frame_d = '0;
        shift_d = 1'b1;
      end else begin
        frame_d = frame_q + FW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      nxt_q   <= '0;
      shown_q <= '0;
      lit_q   <= 1'b0;
      frame_q <= '0;
      snap_q  <= '0;
      seg_q   <= 7'h7F;
      an_q    <= '1;
      shift_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      nxt_q   <= nxt_d;
      shown_q <= shown_d;
      lit_q   <= lit_d;
      frame_q <= frame_d;
      snap_q  <= snap_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      shift_q <= shift_d;
    end
  end

  assign bus.an       = an_q;
  assign bus.seg      = seg_q;
  assign bus.shift_en = shift_q;

endmodule

`default_nettype wire
